// File: rtl/seq_threshold_ctrl.sv
// Start/done sequencer around an accumulating datapath: after a start it sums d and
// walks through STAGES wait stages, each ended by a programmable accumulator bit or a timeout.
module seq_threshold_ctrl #(
  parameter int WIDTH   = 16,
  parameter int STAGES  = 2,
  parameter int TIMEOUT = 255,
  parameter int IDX_W   = $clog2(WIDTH),
  parameter int SW      = $clog2(STAGES) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WIDTH-1:0]        d,
  input  logic                    d_valid,
  input  logic [STAGES*IDX_W-1:0] cfg_bit,
  output logic [WIDTH-1:0]        acc,
  output logic [SW-1:0]           stage,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout
);

  // tcnt never needs to hold more than TIMEOUT-1
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [IDX_W-1:0] sel_idx;
  logic             hit;

  // Bit-index compare loop makes an out-of-range field simply never hit
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stage_q == SW'(k)) sel_idx = cfg_bit[k*IDX_W +: IDX_W];
    end
    hit = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      if (sel_idx == IDX_W'(b)) hit = acc_q[b];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    stage_d = stage_q;
    tcnt_d  = tcnt_q;
    if (start) begin
      state_d = CLEAR;
      acc_d   = '0;
      stage_d = '0;
      tcnt_d  = '0;
    end else if (abort) begin
      state_d = IDLE;
      tcnt_d  = '0;
    end else begin
      unique case (state_q)
        CLEAR: state_d = RUN;
        RUN: begin
          if (d_valid) acc_d = acc_q + d;
          if (hit) begin
            if (stage_q == SW'(STAGES - 1)) begin
              state_d = DONE;
            end else begin
              stage_d = stage_q + 1'b1;
              tcnt_d  = '0;
            end
          end else if ((TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1))) begin
            state_d = ERR;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      stage_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      stage_q <= stage_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign acc     = acc_q;
  assign stage   = stage_q;
  assign busy    = (state_q == CLEAR) || (state_q == RUN);
  assign done    = (state_q == DONE);
  assign timeout = (state_q == ERR);

endmodule

// File: doc/seq_threshold_ctrl.md
Name: seq_threshold_ctrl

Overview:
- Parametrised controller-plus-datapath sequencer for start/done control of an accumulating datapath.
- On `start`, clears an internal accumulator, then sums `d` on every valid cycle.
- Steps through STAGES wait stages. Each stage completes when a per-stage programmable accumulator bit is set.
- Raises `done` after the last stage. Adds abort, per-stage timeout with error reporting, and status outputs.

Parameters:
- WIDTH, 16, width of `d` and of the accumulator.
- STAGES, 2, number of wait stages (1..16).
- TIMEOUT, 255, max RUN cycles spent in one stage; 0 disables the timeout.
- IDX_W, $clog2(WIDTH), width of one bit-index field.
- SW, $clog2(STAGES)+1, width of the stage index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  synchronous (re)start request; highest priority after reset.
- abort  in  1  synchronous abort; returns the block to IDLE.
- d  in  WIDTH  data to accumulate.
- d_valid  in  1  `d` is valid this cycle.
- cfg_bit  in  STAGES*IDX_W  field k (bits k*IDX_W +: IDX_W) = accumulator bit that completes stage k; must be stable while busy.
- acc  out  WIDTH  current accumulator value (registered).
- stage  out  SW  current stage index.
- busy  out  1  high in CLEAR or RUN.
- done  out  1  high in DONE.
- timeout  out  1  high in ERR.

Behaviour:
- States: IDLE, CLEAR, RUN, DONE, ERR.
- Reset (`reset_n`=0, asynchronous): state=IDLE, acc=0, stage=0, tcnt=0. Outputs: busy=0, done=0, timeout=0.
- Priority on each edge: start > abort > stage advance > timeout > hold/count.
- start=1, any state: next state=CLEAR. acc, stage and tcnt load 0 on the same edge. A start during RUN, DONE or ERR restarts cleanly.
- abort=1 with start=0: next state=IDLE. acc and stage are held (readable); tcnt=0.
- IDLE: waits for start. `d` is ignored.
- CLEAR: lasts exactly 1 cycle, then RUN. No accumulation.
- RUN accumulation: if d_valid, acc <= acc + d, modulo 2^WIDTH with silent wrap and no carry out.
- RUN condition: evaluated on the registered acc, i.e. the value before this cycle's add. hit = acc[cfg_bit field stage].
- hit and stage==STAGES-1: next state=DONE; stage held.
- hit and stage<STAGES-1: stage <= stage+1, tcnt <= 0, remain in RUN.
- Accumulation continues on the same edge as any advance.
- No hit: if TIMEOUT!=0 and tcnt==TIMEOUT-1, next state=ERR; else tcnt <= tcnt+1.
- DONE and ERR are terminal until start (or abort/reset). acc frozen; `d` ignored.
- Minimum latency with a pre-set condition bit: start edge E0 -> CLEAR; E1 -> RUN; DONE at edge E(1+STAGES) at the earliest.
- All outputs are Moore (state/register-derived); no combinational path from inputs to outputs.
- Out-of-range cfg_bit field (>=WIDTH): treated as never hit; only a timeout can end the stage.

Test Plan:
- Nominal: WIDTH=16, STAGES=2, cfg_bit stage0=2, stage1=3, d=1, d_valid=1, pulse start at E0.
  - acc=0 at E1, 4 at E5.
  - stage=1 at E6, acc=8 at E9.
  - DONE at E10 with acc=9, done=1, busy=0.
- Timeout: TIMEOUT=8, d_valid=0, start at E0.
  - tcnt counts 0..7 over E1..E8.
  - ERR at E9: timeout=1, stage=0, acc=0.
- Wrap: d=16'hFFFF then d=16'h0002 in RUN -> acc=16'hFFFF, then 16'h0001.
- Restart and abort:
  - start asserted while in RUN stage1 -> next edge CLEAR with acc=0, stage=0. Completes nominally afterwards.
  - abort in RUN -> IDLE next edge, acc held.
- Async reset: reset_n low mid-RUN, between clock edges -> state=IDLE, acc=0, all flags 0 immediately. After release, no activity until start.
- Simultaneous events:
  - start=1 and abort=1 together -> CLEAR.
  - hit on the same cycle as tcnt==TIMEOUT-1 -> stage advances; no ERR.
